// File: rtl/fpga_icg_pkg.sv
// Shared types and sizing helper for the FPGA clock-enable gating controller.
package fpga_icg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } icg_state_e;

    // Counter width able to hold the larger of the idle and wake periods.
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int max_cycles;
        max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/fpga_icg_ch.sv
// One gated channel: RUN/IDLE/GATED/WAKE FSM, shared down-counter, registered
// clock enable, gated status and wake acknowledge.
module fpga_icg_ch
    import fpga_icg_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic force_on,
    input  logic auto_en,
    input  logic busy,
    input  logic wake_req,
    output logic wake_ack,
    output logic clk_en,
    output logic gated
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    icg_state_e       state;
    icg_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             act;

    // Anything that keeps the channel's clock running this cycle.
    assign act = busy | wake_req | ~auto_en | force_on;

    // Next-state and counter logic; a started WAKE always runs to completion.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (!act) begin
                    state_nxt = IDLE;
                    cnt_nxt   = IDLE_LOAD;
                end
            end
            IDLE: begin
                if (act) begin
                    state_nxt = RUN;
                end else if (cnt == '0) begin
                    state_nxt = GATED;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GATED: begin
                if (act) begin
                    state_nxt = WAKE;
                    cnt_nxt   = WAKE_LOAD;
                end
            end
            WAKE: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register; enable and status are registered from the next state so
    // they line up with the state they describe and have no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            cnt    <= '0;
            clk_en <= 1'b1;
            gated  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            clk_en <= (state_nxt != GATED);
            gated  <= (state_nxt == GATED);
        end
    end

    // Acknowledge only once the clock is settled and running for the requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            wake_ack <= 1'b0;
        end else begin
            wake_ack <= wake_req & ((state == RUN) | (state == IDLE));
        end
    end

endmodule

// File: rtl/fpga_icg_ctrl.sv
// Multi-channel clock-enable gating controller: one independent fpga_icg_ch per
// channel, sharing only clock, reset and the debug force_on.
module fpga_icg_ctrl
    import fpga_icg_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              force_on,
    input  logic [NUM_CH-1:0] ch_auto_en,
    input  logic [NUM_CH-1:0] ch_busy,
    input  logic [NUM_CH-1:0] ch_wake_req,
    output logic [NUM_CH-1:0] ch_wake_ack,
    output logic [NUM_CH-1:0] ch_clk_en,
    output logic [NUM_CH-1:0] ch_gated
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("fpga_icg_ctrl: NUM_CH must be >= 1");
    end
    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("fpga_icg_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("fpga_icg_ctrl: WAKE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fpga_icg_ch #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .force_on (force_on),
            .auto_en  (ch_auto_en[i]),
            .busy     (ch_busy[i]),
            .wake_req (ch_wake_req[i]),
            .wake_ack (ch_wake_ack[i]),
            .clk_en   (ch_clk_en[i]),
            .gated    (ch_gated[i])
        );
    end

endmodule

// File: tb/tb_fpga_icg_ctrl.sv
// Bench for fpga_icg_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an idle-streak reference model.
module tb_fpga_icg_ctrl;

    localparam int NUM_CH      = 4;
    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;

    logic              clk;
    logic              rst;
    logic              force_on;
    logic [NUM_CH-1:0] ch_auto_en;
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] ch_wake_req;
    logic [NUM_CH-1:0] ch_wake_ack;
    logic [NUM_CH-1:0] ch_clk_en;
    logic [NUM_CH-1:0] ch_gated;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Reference model: count of consecutive idle samples, gated flag, remaining
    // settle cycles, and the acknowledge the requester should see.
    int m_streak [NUM_CH];
    bit m_gated  [NUM_CH];
    int m_wake   [NUM_CH];
    bit m_ack    [NUM_CH];

    logic [NUM_CH-1:0] exp_en;
    logic [NUM_CH-1:0] exp_gated;
    logic [NUM_CH-1:0] exp_ack;

    fpga_icg_ctrl #(
        .NUM_CH      (NUM_CH),
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .force_on    (force_on),
        .ch_auto_en  (ch_auto_en),
        .ch_busy     (ch_busy),
        .ch_wake_req (ch_wake_req),
        .ch_wake_ack (ch_wake_ack),
        .ch_clk_en   (ch_clk_en),
        .ch_gated    (ch_gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit act_of(input int i);
        return ch_busy[i] | ch_wake_req[i] | ~ch_auto_en[i] | force_on;
    endfunction

    // Model update on each rising edge from the inputs sampled there.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                m_streak[i] <= 0;
                m_gated[i]  <= 1'b0;
                m_wake[i]   <= 0;
                m_ack[i]    <= 1'b0;
            end else begin
                m_ack[i] <= ch_wake_req[i] && !m_gated[i] && (m_wake[i] == 0);
                if (m_wake[i] > 0) begin
                    m_wake[i] <= m_wake[i] - 1;
                end else if (m_gated[i]) begin
                    if (act_of(i)) begin
                        m_gated[i] <= 1'b0;
                        m_wake[i]  <= WAKE_CYCLES;
                    end
                end else if (act_of(i)) begin
                    m_streak[i] <= 0;
                end else if (m_streak[i] + 1 > IDLE_CYCLES) begin
                    m_gated[i]  <= 1'b1;
                    m_streak[i] <= 0;
                end else begin
                    m_streak[i] <= m_streak[i] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NUM_CH; i++) begin
                exp_en[i]    = !m_gated[i];
                exp_gated[i] = m_gated[i];
                exp_ack[i]   = m_ack[i];
            end
            checks = checks + 3;
            if (ch_clk_en !== exp_en) begin
                failures++;
                $display("FAIL model_clk_en t=%0t got=%b expected=%b", $time, ch_clk_en, exp_en);
            end
            if (ch_gated !== exp_gated) begin
                failures++;
                $display("FAIL model_gated t=%0t got=%b expected=%b", $time, ch_gated, exp_gated);
            end
            if (ch_wake_ack !== exp_ack) begin
                failures++;
                $display("FAIL model_wake_ack t=%0t got=%b expected=%b", $time, ch_wake_ack, exp_ack);
            end
        end
    end

    task automatic check_lit(input string name, input logic [NUM_CH-1:0] actual,
                             input logic [NUM_CH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, actual, expected);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        force_on    = 1'b0;
        ch_auto_en  = '1;
        ch_busy     = '0;
        ch_wake_req = '0;
        repeat (2) cyc();
        chk_on = 1'b1;

        // Reset state
        check_lit("reset_clk_en", ch_clk_en, 4'hF);
        check_lit("reset_gated", ch_gated, 4'h0);
        check_lit("reset_ack", ch_wake_ack, 4'h0);

        // 1: release with no activity -> enable high five cycles, then gated
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_lit("t1_run_window", ch_clk_en, 4'hF);
        end
        cyc();
        check_lit("t1_gate_clk_en", ch_clk_en, 4'h0);
        check_lit("t1_gate_status", ch_gated, 4'hF);
        rst = 1'b1;
        cyc();
        check_lit("t1_reset_while_gated", ch_clk_en, 4'hF);
        check_lit("t1_reset_gated_clear", ch_gated, 4'h0);
        rst = 1'b0;
        repeat (5) cyc();
        check_lit("t1_regated", ch_gated, 4'hF);

        // 3: wake handshake on ch2
        ch_wake_req = 4'b0100;
        cyc();
        check_lit("t3_en_after_w", ch_clk_en, 4'b0100);
        check_lit("t3_ack_w", ch_wake_ack, 4'b0000);
        cyc();
        check_lit("t3_ack_w1", ch_wake_ack, 4'b0000);
        cyc();
        check_lit("t3_ack_w2", ch_wake_ack, 4'b0000);
        cyc();
        check_lit("t3_ack_w3", ch_wake_ack, 4'b0100);
        ch_wake_req = 4'b0000;
        cyc();
        check_lit("t3_ack_drop", ch_wake_ack, 4'b0000);

        // 4: activity exactly when the idle count expires keeps ch2 running
        repeat (3) cyc();
        ch_busy = 4'b0100;
        cyc();
        check_lit("t4_no_gate_at_zero", ch_clk_en, 4'b0100);
        ch_busy = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_lit("t4_full_recount", ch_clk_en, 4'b0100);
        end
        cyc();
        check_lit("t4_gate_after_recount", ch_clk_en, 4'b0000);

        // 5: force_on wakes everything, never gates, regates after release
        force_on = 1'b1;
        cyc();
        check_lit("t5_force_wake_en", ch_clk_en, 4'hF);
        check_lit("t5_force_wake_gated", ch_gated, 4'h0);
        repeat (10) cyc();
        check_lit("t5_force_hold", ch_clk_en, 4'hF);
        force_on = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_lit("t5_release_window", ch_clk_en, 4'hF);
        end
        cyc();
        check_lit("t5_regate", ch_clk_en, 4'h0);

        // 6: auto_en low on ch3 holds it ungated
        ch_auto_en = 4'b0111;
        repeat (12) cyc();
        check_lit("t6_ch3_on", ch_clk_en, 4'b1000);
        check_lit("t6_others_gated", ch_gated, 4'b0111);
        ch_auto_en = '1;

        // 2: busy pulse every third cycle on ch0
        for (int k = 0; k < 30; k++) begin
            ch_busy = (k % 3 == 0) ? 4'b0001 : 4'b0000;
            cyc();
        end
        check_lit("t2_ch0_running", ch_clk_en, 4'b0001);
        ch_busy = '0;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int bp;
            cyc();
            bp = ((c / 400) % 2 == 0) ? 30 : 5;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_busy[i] = ($urandom_range(0, 99) < bp);
                if ($urandom_range(0, 199) == 0) ch_auto_en[i] = ~ch_auto_en[i];
                if (ch_wake_req[i]) begin
                    if (m_ack[i] || $urandom_range(0, 49) == 0) ch_wake_req[i] = 1'b0;
                end else if (m_gated[i] && $urandom_range(0, 9) == 0) begin
                    ch_wake_req[i] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    ch_wake_req[i] = 1'b1;
                end
            end
            if (force_on) begin
                if ($urandom_range(0, 19) == 0) force_on = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                force_on = 1'b1;
            end
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
        cyc();
        chk_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
